// File: rtl/sr4_pkg.sv
// sr4_pkg
// Shared definitions for the SR4 serializer controller.
//   state_t  : controller FSM states (idle, shifting, inter-word gap)
//   GAP_MAX  : largest supported number of forced idle cycles between words
//   GAP_W    : width of the gap counter, sized to hold GAP_MAX
package sr4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GAP_MAX = 15;
    localparam int GAP_W   = 4;

endpackage

// File: rtl/sr4.sv
// sr4
// 4-bit parallel-load / shift-right register.
//   clk : rising-edge clock
//   L   : 1 = load R into Q, 0 = shift right with w entering at Q[3]
//   R   : parallel load value
//   w   : serial input for the shift
//   Q   : register contents (Q[0] is the bit leaving next)
// Q is intentionally not reset; the controller only qualifies Q[0]
// through sout_valid, so its power-up value never escapes.
module sr4 (
    input  logic       clk,
    input  logic       L,
    input  logic [3:0] R,
    input  logic       w,
    output logic [3:0] Q
);

    always_ff @(posedge clk) begin
        if (L) begin
            Q <= R;
        end else begin
            Q <= {w, Q[3:1]};
        end
    end

endmodule

// File: rtl/sr4_tx_ctrl.sv
// sr4_tx_ctrl
// Serializes 4-bit words LSB first through one SR4 instance using a
// valid/ready handshake on both sides.
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   din        : parallel word to send
//   din_valid  : din holds a word
//   din_ready  : word on din is accepted this cycle
//   sout       : serial bit (SR4 Q[0])
//   sout_valid : sout holds a valid bit
//   sout_ready : sink takes sout this cycle
//   done       : one-cycle pulse after the last bit of a word transfers
//   busy       : controller is not idle
// Parameters:
//   GAP  : idle cycles forced between words (0..GAP_MAX)
//   FILL : value shifted into the top of the register
module sr4_tx_ctrl
    import sr4_pkg::*;
#(
    parameter int   GAP  = 0,
    parameter logic FILL = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sout,
    output logic       sout_valid,
    input  logic       sout_ready,
    output logic       done,
    output logic       busy
);

    // Out-of-range GAP values saturate at the largest supported gap.
    localparam int              GAP_EFF  = (GAP > GAP_MAX) ? GAP_MAX : GAP;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_EFF > 0) ? GAP_W'(GAP_EFF - 1) : '0;

    state_t           state;
    state_t           next_state;
    logic [1:0]       cnt;
    logic [1:0]       next_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] next_gap;
    logic             done_q;
    logic             next_done;

    logic             sr_load;
    logic [3:0]       sr_data;
    logic [3:0]       q;
    logic             ready_int;
    logic             valid_int;

    sr4 u_sr4 (
        .clk (clk),
        .L   (sr_load),
        .R   (sr_data),
        .w   (FILL),
        .Q   (q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            gap_cnt <= next_gap;
            done_q  <= next_done;
        end
    end

    // Default is "reload Q with itself", so any cycle that is not an
    // explicit shift or new-word load holds the register (this is how a
    // stalled bit stays on sout).
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_gap   = gap_cnt;
        next_done  = 1'b0;
        sr_load    = 1'b1;
        sr_data    = q;
        ready_int  = 1'b0;
        valid_int  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (din_valid) begin
                    sr_data    = din;
                    next_cnt   = 2'd0;
                    next_state = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                valid_int = 1'b1;
                if (sout_ready) begin
                    if (cnt != 2'd3) begin
                        sr_load  = 1'b0;
                        next_cnt = cnt + 2'd1;
                    end else begin
                        next_done = 1'b1;
                        if (GAP_EFF == 0) begin
                            // Last bit leaves while the next word loads,
                            // so consecutive words have no bubble.
                            ready_int = 1'b1;
                            if (din_valid) begin
                                sr_data  = din;
                                next_cnt = 2'd0;
                            end else begin
                                next_state = ST_IDLE;
                            end
                        end else begin
                            next_gap   = GAP_LOAD;
                            next_state = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt == '0) begin
                    next_state = ST_IDLE;
                end else begin
                    next_gap = gap_cnt - 1'b1;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // din_ready is gated by resetn so nothing is accepted while reset is held.
    assign din_ready  = resetn & ready_int;
    assign sout_valid = valid_int;
    assign sout       = q[0];
    assign done       = done_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: doc/sr4_tx_ctrl.md
SR4_TX_CTRL -- requirements
Module: sr4_tx_ctrl

Interface
REQ-001 Parameter GAP, default 0, meaning idle cycles forced between words (range 0..15).
REQ-002 Parameter FILL, default 1'b0, meaning the value driven onto the shift register serial input w.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 din  input  4  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word.
REQ-007 din_ready  output  1  block accepts din this cycle.
REQ-008 sout  output  1  serial bit, LSB first.
REQ-009 sout_valid  output  1  sout holds a valid bit.
REQ-010 sout_ready  input  1  sink takes sout this cycle.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word transfers.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL sequence one SR4 instance: it drives L, R[3:0] and w (w=FILL), and sout SHALL equal SR4 Q[0].
REQ-014 The FSM SHALL have states IDLE, SHIFT and GAP, plus a 2-bit bit counter cnt.
REQ-015 IDLE: din_ready=1, sout_valid=0; on din_valid, L=1 and R=din; at the edge, Q<=din, cnt<=0, state->SHIFT.
REQ-016 SHIFT: sout_valid=1; a bit transfers on an edge with sout_ready=1.
REQ-017 SHIFT with sout_ready=1 and cnt<3: L=0, Q shifts right (Q[3]<=FILL), cnt<=cnt+1.
REQ-018 SHIFT with sout_ready=0: L=1 and R=Q, so Q, sout and cnt SHALL hold unchanged.
REQ-019 SHIFT with sout_ready=1 and cnt==3 is the last bit; done SHALL be high in the following cycle only.
REQ-020 On the last bit with GAP==0: din_ready=1; if din_valid, load din (L=1, R=din), cnt<=0, stay in SHIFT, giving a gapless stream; else go to IDLE.
REQ-021 On the last bit with GAP>0: go to GAP with a gap counter set to GAP-1; in GAP, din_ready=0 and sout_valid=0; when the counter reaches 0, go to IDLE.
REQ-022 din_ready SHALL be 0 in SHIFT, except on the last-bit cycle when GAP==0.
REQ-023 Latency: a word accepted at edge k SHALL present bit i on sout in cycle k+1+i when sout_ready is held high.
REQ-024 Simultaneous din_valid and a held (stalled) last bit: no load; the word waits.

Reset
REQ-025 resetn low SHALL asynchronously force state=IDLE, cnt=0, the gap counter=0, done=0, sout_valid=0, busy=0 and din_ready=0 while asserted; din_ready SHALL be 1 from the first cycle after release.
REQ-026 Reset mid-word SHALL discard the partial word; SR4 Q is unreset, and its contents are don't-care while sout_valid=0.

Structure
REQ-027 State encoding and the GAP range constant SHALL live in a shared package sr4_pkg.
REQ-028 The sole sub-module SHALL be the SR4 shift register; the controller adds no further datapath storage.

Verification
REQ-029 Reset release, din=4'b1011 valid 1 cycle, sout_ready=1 -> sout 1,1,0,1 in cycles k+1..k+4, done in k+5, busy k+1..k+4.
REQ-030 GAP=0, back-to-back 4'hA then 4'h5 -> 8 contiguous valid bits 0,1,0,1,1,0,1,0, no sout_valid bubble, two done pulses.
REQ-031 4'b0110 with sout_ready low for 3 cycles after bit 1 -> sout holds 1 during the stall; sequence 0,1,1,0 intact; cnt unchanged during the stall.
REQ-032 GAP=3 with two words queued -> 3 cycles of sout_valid=0 and din_ready=0 between words; second word accepted in IDLE.
REQ-033 resetn pulsed low after bit 2 of 4'hF -> immediate IDLE, sout_valid=0, no done; the next word 4'h3 serializes correctly as 1,1,0,0.
REQ-034 FILL=1 with sout_ready toggling every cycle -> the bit order is preserved and exactly 4 transfers occur per word.
